// File: rtl/cover_toggle_collector_pkg.sv
// Shared cover-index constants, the cover index type and the popcount helper
// used by the toggle-coverage collectors.
package cover_pkg;

  localparam int COVER_TOTAL = 38253;
  localparam int COVER_IDX_W = 16;

  typedef logic [COVER_IDX_W-1:0] cover_idx_t;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cover_toggle_collector_fifo.sv
// Report FIFO: registered head, push visible the cycle after the write, no bypass.
// Push while full only succeeds together with a pop; clear empties it and wins over push/pop.
module cover_report_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-coverage collector: streams each newly hit bit's global index once,
// lowest pending bit first, 2-cycle minimum latency; full FIFO parks bits in pending, valid never stalls.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int WIDTH       = 21,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = COVER_IDX_W,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       all_covered
);

  localparam int CW   = $clog2(WIDTH + 1);
  localparam int SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH must be within 1..64");
  end
  if (longint'(COVER_INDEX) + longint'(WIDTH) - 1 >= (longint'(1) << IDX_W)) begin : g_bad_index
    $error("cover_toggle_collector: COVER_INDEX+WIDTH-1 does not fit in IDX_W bits");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cover_toggle_collector: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_bits;
  logic [WIDTH-1:0] pend_clr;
  logic [SW-1:0]    sel;
  logic [CW-1:0]    hc_next;
  logic             can_accept;
  logic             push;
  logic [IDX_W-1:0] push_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;

  assign new_bits = valid & ~hit;
  assign hc_next  = hit_count + CW'(popcount(64'(new_bits)));

  // Lowest set pending bit wins, so simultaneous hits report in ascending order.
  always_comb begin
    sel = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) sel = SW'(i);
    end
  end

  assign out_valid  = !fifo_empty;
  assign can_accept = !fifo_full || (out_valid && out_ready);
  assign push       = (pending != '0) && can_accept;
  assign push_data  = IDX_W'(COVER_INDEX) + IDX_W'(sel);

  always_comb begin
    pend_clr = '0;
    if (push) pend_clr[sel] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit         <= '0;
      pending     <= '0;
      hit_count   <= '0;
      all_covered <= 1'b0;
    end else if (clear) begin
      hit         <= '0;
      pending     <= '0;
      hit_count   <= '0;
      all_covered <= 1'b0;
    end else begin
      hit         <= hit | valid;
      pending     <= (pending & ~pend_clr) | new_bits;
      hit_count   <= hc_next;
      all_covered <= (hc_next == CW'(WIDTH));
    end
  end

  cover_report_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (IDX_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (out_index),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_fifo_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
    fifo_count <= FCW'(FIFO_DEPTH));

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector with WIDTH=21, COVER_INDEX=100, FIFO_DEPTH=8.
module tb_cover_toggle_collector;

  logic        clock;
  logic        reset_n;
  logic [20:0] valid;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_index;
  logic [4:0]  hit_count;
  logic        all_covered;

  int n_checks = 0;
  int n_err    = 0;

  cover_toggle_collector #(
    .WIDTH       (21),
    .COVER_INDEX (100),
    .IDX_W       (16),
    .FIFO_DEPTH  (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid       (valid),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .hit_count   (hit_count),
    .all_covered (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse placed between edges; returns aligned 1 time unit after an edge.
  task automatic pulse_reset();
    valid     = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
  endtask

  // Consume n reports expecting first_idx, first_idx+1, ...; optionally stall every other cycle.
  task automatic drain(input string tag, input int first_idx, input int n, input bit toggle);
    int          got;
    int          cyc;
    int          gaps;
    bit          started;
    bit          stalled;
    logic [15:0] held;
    got     = 0;
    cyc     = 0;
    gaps    = 0;
    started = 1'b0;
    stalled = 1'b0;
    held    = '0;
    while (got < n && cyc < 200) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      if (stalled) begin
        check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_stall_stable"}, {16'd0, out_index}, {16'd0, held});
      end
      stalled = 1'b0;
      if (out_valid) begin
        started = 1'b1;
        if (out_ready) begin
          check({tag, "_order"}, {16'd0, out_index}, first_idx + got);
          got++;
        end else begin
          held    = out_index;
          stalled = 1'b1;
        end
      end else if (started) begin
        gaps++;
      end
      tick();
      cyc++;
    end
    check({tag, "_count"}, got, n);
    if (!toggle) check({tag, "_gaps"}, gaps, 0);
  endtask

  task automatic count_reports(input string tag, input int cycles, input int exp);
    int seen;
    seen      = 0;
    out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check(tag, seen, exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    valid     = 21'h1FFFFF;
    clear     = 1'b0;
    out_ready = 1'b0;

    // Reset held with all inputs hot.
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hit_count", {27'd0, hit_count}, 32'd0);
    check("rst_all_cov", {31'd0, all_covered}, 32'd0);
    check("rst_out_index", {16'd0, out_index}, 32'd0);
    valid = '0;
    #2 reset_n = 1'b1;
    tick();
    repeat (3) tick();
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_hit_count", {27'd0, hit_count}, 32'd0);

    // Two bits in one cycle: reports 100 then 102 with latency 2.
    out_ready = 1'b1;
    valid     = 21'h000005;
    tick();
    valid = '0;
    check("lat_t1_hit_count", {27'd0, hit_count}, 32'd2);
    check("lat_t1_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_t2_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_t2_out_index", {16'd0, out_index}, 32'd100);
    tick();
    check("lat_t3_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_t3_out_index", {16'd0, out_index}, 32'd102);
    tick();
    check("lat_t4_out_valid", {31'd0, out_valid}, 32'd0);

    // Re-hitting covered bits produces nothing new.
    valid = 21'h000005;
    count_reports("rehit_reports", 10, 0);
    valid = '0;
    count_reports("rehit_tail", 3, 0);
    check("rehit_hit_count", {27'd0, hit_count}, 32'd2);
    check("rehit_all_cov", {31'd0, all_covered}, 32'd0);

    // Everything at once with the consumer stalled, then a full-rate drain.
    pulse_reset();
    valid = 21'h1FFFFF;
    tick();
    valid = '0;
    check("all_hit_count", {27'd0, hit_count}, 32'd21);
    check("all_all_cov", {31'd0, all_covered}, 32'd1);
    repeat (12) tick();
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_head", {16'd0, out_index}, 32'd100);
    drain("drain", 100, 21, 1'b0);
    count_reports("drain_extra", 6, 0);

    // Same load, drained with the consumer stalling every other cycle.
    pulse_reset();
    valid = 21'h1FFFFF;
    tick();
    valid = '0;
    repeat (4) tick();
    drain("bp", 100, 21, 1'b1);
    count_reports("bp_extra", 6, 0);

    // Clear after five pops, then a single top bit.
    pulse_reset();
    valid = 21'h1FFFFF;
    tick();
    valid = '0;
    repeat (10) tick();
    drain("pre_clr", 100, 5, 1'b0);
    out_ready = 1'b1;
    clear     = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_hit_count", {27'd0, hit_count}, 32'd0);
    check("clr_all_cov", {31'd0, all_covered}, 32'd0);
    count_reports("clr_quiet", 4, 0);
    valid = 21'h100000;
    tick();
    valid = '0;
    check("single_hit_count", {27'd0, hit_count}, 32'd1);
    drain("single", 120, 1, 1'b0);
    count_reports("single_extra", 6, 0);

    // Asynchronous reset between edges during a drain.
    pulse_reset();
    out_ready = 1'b1;
    valid     = 21'h1FFFFF;
    tick();
    valid = '0;
    repeat (4) tick();
    check("arst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_index", {16'd0, out_index}, 32'd0);
    check("arst_hit_count", {27'd0, hit_count}, 32'd0);
    check("arst_all_cov", {31'd0, all_covered}, 32'd0);
    #1 reset_n = 1'b1;
    tick();
    count_reports("arst_after", 30, 0);
    check("arst_after_hits", {27'd0, hit_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
